// File: rtl/hazard_forward_unit.sv
// ============================================================================
// hazard_forward_unit
// ----------------------------------------------------------------------------
// Hazard detection and operand forwarding for the ID stage of the classic
// 5-stage pipeline (IF, ID, EX, MEM, WB).
//
// The unit keeps its own shadow copy of the destination of every instruction
// in EX, MEM and WB. Each copy is a small record {rd, we, load}. The unit
// compares the ID-stage source operands against those records and produces
// three groups of outputs:
//   * hazard_stall - select of the ID control-signal mux (1 = bubble)
//   * pc_le / ifid_le / ifid_flush - front-end pipeline control
//   * fwd_a / fwd_b - operand source selects for the ID/EX operand muxes
// It also keeps a saturating count of stall cycles for performance reporting.
//
// Ports:
//   clk              in   1       rising-edge clock
//   reset            in   1       synchronous, active-high reset
//   id_valid         in   1       ID holds a real instruction
//   id_rs1, id_rs2   in   REG_AW  source register numbers
//   id_uses_rs1/2    in   1       instruction actually reads rs1 / rs2
//   id_rd            in   REG_AW  destination register number
//   id_rd_we         in   1       instruction writes rd
//   id_is_load       in   1       instruction is a load
//   id_is_branch     in   1       branch/jump resolved in ID
//   id_branch_taken  in   1       branch condition true
//   hazard_stall     out  1       1 = zero the control signals (bubble)
//   pc_le, ifid_le   out  1       PC / IF-ID load enables
//   ifid_flush       out  1       clear IF/ID on the next edge
//   fwd_a, fwd_b     out  2       00 regfile, 01 EX, 10 MEM, 11 WB
//   stall_count      out  CNT_W   saturating number of stall cycles
// ============================================================================
module hazard_forward_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              id_is_branch,
    input  logic              id_branch_taken,
    output logic              hazard_stall,
    output logic              pc_le,
    output logic              ifid_le,
    output logic              ifid_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_count
);

    // Forwarding source encodings shared by both operand muxes.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // Shadow record of one in-flight instruction's destination.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              load;
    } track_rec_t;

    // The WB record carries no load flag: by WB a load's data is the final
    // writeback value, so it forwards exactly like an ALU result.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              we;
    } wb_rec_t;

    track_rec_t ex_rec;
    track_rec_t mem_rec;
    wb_rec_t    wb_rec;
    track_rec_t ex_next;

    logic ex_hit_a;
    logic ex_hit_b;
    logic mem_hit_a;
    logic mem_hit_b;
    logic wb_hit_a;
    logic wb_hit_b;
    logic load_use_stall;
    logic branch_stall;
    logic stall_raw;

    // ------------------------------------------------------------------------
    // A record "hits" an operand only when the record really writes a
    // register, the register is the one being read, the register is not the
    // hardwired-zero r0, the operand is actually used, and ID is valid.
    // ------------------------------------------------------------------------
    function automatic logic rec_match(
        input logic              rec_we,
        input logic [REG_AW-1:0] rec_rd,
        input logic [REG_AW-1:0] rs,
        input logic              uses_rs,
        input logic              valid
    );
        return rec_we && (rec_rd == rs) && (rs != '0) && uses_rs && valid;
    endfunction

    // ------------------------------------------------------------------------
    // Forwarding priority: the youngest producer wins. An EX hit on a load
    // deliberately selects the register file, since the data does not exist
    // yet and the stall logic is already holding ID for that case; it must
    // not fall through to an older (stale) MEM or WB value.
    // ------------------------------------------------------------------------
    function automatic logic [1:0] fwd_select(
        input logic ex_hit,
        input logic ex_is_load,
        input logic mem_hit,
        input logic wb_hit
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (ex_hit) begin
            sel = ex_is_load ? FWD_RF : FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // ------------------------------------------------------------------------
    // Operand hit detection against each of the three records.
    // ------------------------------------------------------------------------
    always_comb begin
        ex_hit_a  = rec_match(ex_rec.we,  ex_rec.rd,  id_rs1, id_uses_rs1, id_valid);
        ex_hit_b  = rec_match(ex_rec.we,  ex_rec.rd,  id_rs2, id_uses_rs2, id_valid);
        mem_hit_a = rec_match(mem_rec.we, mem_rec.rd, id_rs1, id_uses_rs1, id_valid);
        mem_hit_b = rec_match(mem_rec.we, mem_rec.rd, id_rs2, id_uses_rs2, id_valid);
        wb_hit_a  = rec_match(wb_rec.we,  wb_rec.rd,  id_rs1, id_uses_rs1, id_valid);
        wb_hit_b  = rec_match(wb_rec.we,  wb_rec.rd,  id_rs2, id_uses_rs2, id_valid);
    end

    // ------------------------------------------------------------------------
    // Stall decision. A load in EX cannot feed anything yet. A branch compares
    // in ID, so it additionally needs any EX result (not yet computed in time
    // for ID) and a load sitting in MEM (data arrives only at the end of MEM).
    // Both conditions may coincide; they simply OR into one stall.
    // ------------------------------------------------------------------------
    always_comb begin
        load_use_stall = (ex_hit_a || ex_hit_b) && ex_rec.load;
        branch_stall   = id_is_branch &&
                         ((ex_hit_a || ex_hit_b) ||
                          ((mem_hit_a || mem_hit_b) && mem_rec.load));
        stall_raw      = load_use_stall || branch_stall;
    end

    // ------------------------------------------------------------------------
    // Output generation. Reset forces every control output to its idle value
    // so the pipeline runs freely while the unit is being cleared. A stalled
    // branch does not flush; it flushes on the cycle it finally resolves.
    // ------------------------------------------------------------------------
    always_comb begin
        hazard_stall = 1'b0;
        ifid_flush   = 1'b0;
        fwd_a        = FWD_RF;
        fwd_b        = FWD_RF;
        if (!reset) begin
            hazard_stall = stall_raw;
            ifid_flush   = id_valid && id_is_branch && id_branch_taken && !stall_raw;
            fwd_a        = fwd_select(ex_hit_a, ex_rec.load, mem_hit_a, wb_hit_a);
            fwd_b        = fwd_select(ex_hit_b, ex_rec.load, mem_hit_b, wb_hit_b);
        end
        pc_le   = !hazard_stall;
        ifid_le = !hazard_stall;
    end

    // ------------------------------------------------------------------------
    // Next EX record: the ID instruction's destination, qualified by id_valid,
    // or an all-zero bubble when the control signals are being zeroed.
    // ------------------------------------------------------------------------
    always_comb begin
        ex_next = '0;
        if (!hazard_stall) begin
            ex_next.rd   = id_rd;
            ex_next.we   = id_rd_we && id_valid;
            ex_next.load = id_is_load && id_valid;
        end
    end

    // ------------------------------------------------------------------------
    // Record pipeline: shifts EX -> MEM -> WB every edge, mirroring the real
    // datapath registers. Reset discards everything in flight, including any
    // bubble being inserted.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rec  <= '0;
            mem_rec <= '0;
            wb_rec  <= '0;
        end else begin
            wb_rec.rd <= mem_rec.rd;
            wb_rec.we <= mem_rec.we;
            mem_rec   <= ex_rec;
            ex_rec    <= ex_next;
        end
    end

    // ------------------------------------------------------------------------
    // Stall counter: one count per stalled cycle, sticking at all-ones so a
    // long run never wraps back to a misleadingly small number.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (hazard_stall && (stall_count != '1)) begin
            stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
